// File: rtl/id_ex_ctrl_pipe.sv
// Decode->execute->memory control pipeline: registers decode control into E and M,
// and resolves branch/jump direction in E to steer the fetch PC mux.
module id_ex_ctrl_pipe #(
    parameter int RESULT_SRC_W = 2,
    parameter int PCSRC_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    StallE,
    input  logic                    FlushE,
    input  logic                    RegWriteD,
    input  logic [RESULT_SRC_W-1:0] ResultSrcD,
    input  logic                    MemWriteD,
    input  logic                    JumpD,
    input  logic                    JalrD,
    input  logic                    BranchD,
    input  logic                    ALUSrcD,
    input  logic [2:0]              funct3D,
    input  logic                    ZeroE,
    input  logic                    LtE,
    input  logic                    LtuE,
    output logic                    RegWriteE,
    output logic [RESULT_SRC_W-1:0] ResultSrcE,
    output logic                    MemWriteE,
    output logic                    ALUSrcE,
    output logic [PCSRC_W-1:0]      PCSrcE,
    output logic                    ValidE,
    output logic                    RegWriteM,
    output logic [RESULT_SRC_W-1:0] ResultSrcM,
    output logic                    MemWriteM,
    output logic                    ValidM
);

    localparam logic [PCSRC_W-1:0] PCSRC_SEQ    = PCSRC_W'(0);
    localparam logic [PCSRC_W-1:0] PCSRC_TARGET = PCSRC_W'(1);
    localparam logic [PCSRC_W-1:0] PCSRC_JALR   = PCSRC_W'(2);

    typedef struct packed {
        logic                    valid;
        logic                    regwrite;
        logic [RESULT_SRC_W-1:0] resultsrc;
        logic                    memwrite;
        logic                    jump;
        logic                    jalr;
        logic                    branch;
        logic                    alusrc;
        logic [2:0]              funct3;
    } e_stage_t;

    typedef struct packed {
        logic                    valid;
        logic                    regwrite;
        logic [RESULT_SRC_W-1:0] resultsrc;
        logic                    memwrite;
    } m_stage_t;

    e_stage_t e_reg, e_next;
    m_stage_t m_reg, m_next;
    logic     branch_taken;

    // Flush beats stall: a bubble is loaded even while the hazard unit asks for a hold.
    always_comb begin
        e_next = e_reg;
        if (FlushE) begin
            e_next = '0;
        end else if (!StallE) begin
            e_next.valid     = 1'b1;
            e_next.regwrite  = RegWriteD;
            e_next.resultsrc = ResultSrcD;
            e_next.memwrite  = MemWriteD;
            e_next.jump      = JumpD;
            e_next.jalr      = JalrD;
            e_next.branch    = BranchD;
            e_next.alusrc    = ALUSrcD;
            e_next.funct3    = funct3D;
        end
    end

    // A held E instruction must not be duplicated into M; a flushed one has already
    // left E (the bubble replaces the younger decode instruction), so it advances.
    always_comb begin
        m_next = '0;
        if (FlushE || !StallE) begin
            m_next.valid     = e_reg.valid;
            m_next.regwrite  = e_reg.regwrite;
            m_next.resultsrc = e_reg.resultsrc;
            m_next.memwrite  = e_reg.memwrite;
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        case (e_reg.funct3)
            3'b000:  branch_taken = ZeroE;
            3'b001:  branch_taken = !ZeroE;
            3'b100:  branch_taken = LtE;
            3'b101:  branch_taken = !LtE;
            3'b110:  branch_taken = LtuE;
            3'b111:  branch_taken = !LtuE;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        PCSrcE = PCSRC_SEQ;
        if (e_reg.valid) begin
            if (e_reg.jalr) begin
                PCSrcE = PCSRC_JALR;
            end else if (e_reg.jump || (e_reg.branch && branch_taken)) begin
                PCSrcE = PCSRC_TARGET;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_reg <= '0;
            m_reg <= '0;
        end else begin
            e_reg <= e_next;
            m_reg <= m_next;
        end
    end

    assign RegWriteE  = e_reg.regwrite;
    assign ResultSrcE = e_reg.resultsrc;
    assign MemWriteE  = e_reg.memwrite;
    assign ALUSrcE    = e_reg.alusrc;
    assign ValidE     = e_reg.valid;
    assign RegWriteM  = m_reg.regwrite;
    assign ResultSrcM = m_reg.resultsrc;
    assign MemWriteM  = m_reg.memwrite;
    assign ValidM     = m_reg.valid;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Self-checking bench for id_ex_ctrl_pipe: directed scenarios followed by random
// traffic, all compared against an instruction-slot model of the E and M stages.
module tb_id_ex_ctrl_pipe;

    logic       clk;
    logic       rst;
    logic       StallE, FlushE;
    logic       RegWriteD, MemWriteD, JumpD, JalrD, BranchD, ALUSrcD;
    logic [1:0] ResultSrcD;
    logic [2:0] funct3D;
    logic       ZeroE, LtE, LtuE;
    logic       RegWriteE, MemWriteE, ALUSrcE, ValidE;
    logic [1:0] ResultSrcE, PCSrcE;
    logic       RegWriteM, MemWriteM, ValidM;
    logic [1:0] ResultSrcM;

    int tests = 0;
    int fails = 0;

    id_ex_ctrl_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .StallE     (StallE),
        .FlushE     (FlushE),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .MemWriteD  (MemWriteD),
        .JumpD      (JumpD),
        .JalrD      (JalrD),
        .BranchD    (BranchD),
        .ALUSrcD    (ALUSrcD),
        .funct3D    (funct3D),
        .ZeroE      (ZeroE),
        .LtE        (LtE),
        .LtuE       (LtuE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .ALUSrcE    (ALUSrcE),
        .PCSrcE     (PCSrcE),
        .ValidE     (ValidE),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .ValidM     (ValidM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction as seen by the pipeline; an all-zero slot is a bubble.
    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic       alusrc;
        logic [2:0] funct3;
    } slot_t;

    slot_t slot_e = '0;
    slot_t slot_m = '0;

    function automatic slot_t decode_slot();
        slot_t s;
        s.valid     = 1'b1;
        s.regwrite  = RegWriteD;
        s.resultsrc = ResultSrcD;
        s.memwrite  = MemWriteD;
        s.jump      = JumpD;
        s.jalr      = JalrD;
        s.branch    = BranchD;
        s.alusrc    = ALUSrcD;
        s.funct3    = funct3D;
        return s;
    endfunction

    function automatic logic [1:0] exp_pcsrc(input slot_t s, input logic z, input logic lt, input logic ltu);
        logic taken;
        if (!s.valid) return 2'b00;
        if (s.jalr) return 2'b10;
        if (s.jump) return 2'b01;
        if (!s.branch) return 2'b00;
        case (s.funct3)
            3'd0:    taken = z;
            3'd1:    taken = !z;
            3'd4:    taken = lt;
            3'd5:    taken = !lt;
            3'd6:    taken = ltu;
            3'd7:    taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken ? 2'b01 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit with_m);
        chk({tag, ".RegWriteE"},  8'(RegWriteE),  8'(slot_e.regwrite));
        chk({tag, ".ResultSrcE"}, 8'(ResultSrcE), 8'(slot_e.resultsrc));
        chk({tag, ".MemWriteE"},  8'(MemWriteE),  8'(slot_e.memwrite));
        chk({tag, ".ALUSrcE"},    8'(ALUSrcE),    8'(slot_e.alusrc));
        chk({tag, ".ValidE"},     8'(ValidE),     8'(slot_e.valid));
        chk({tag, ".PCSrcE"},     8'(PCSrcE),     8'(exp_pcsrc(slot_e, ZeroE, LtE, LtuE)));
        if (with_m) begin
            chk({tag, ".RegWriteM"},  8'(RegWriteM),  8'(slot_m.regwrite));
            chk({tag, ".ResultSrcM"}, 8'(ResultSrcM), 8'(slot_m.resultsrc));
            chk({tag, ".MemWriteM"},  8'(MemWriteM),  8'(slot_m.memwrite));
            chk({tag, ".ValidM"},     8'(ValidM),     8'(slot_m.valid));
        end
        $display("[TB] %s: E v=%0b rw=%0b rs=%0d mw=%0b pc=%0d | M v=%0b rw=%0b rs=%0d mw=%0b",
                 tag, ValidE, RegWriteE, ResultSrcE, MemWriteE, PCSrcE,
                 ValidM, RegWriteM, ResultSrcM, MemWriteM);
    endtask

    // Advance one clock and move the model's instructions along the pipe.
    task automatic clk_edge();
        slot_t next_m;
        @(posedge clk);
        if (!rst) begin
            slot_e = '0;
            slot_m = '0;
        end else begin
            next_m = (StallE && !FlushE) ? slot_t'(0) : slot_e;
            if (FlushE) slot_e = '0;
            else if (!StallE) slot_e = decode_slot();
            slot_m = next_m;
        end
        #1;
    endtask

    task automatic drive(input logic rw, input logic [1:0] rs, input logic mw, input logic j,
                         input logic jr, input logic br, input logic as, input logic [2:0] f3,
                         input logic st, input logic fl);
        RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw; JumpD = j;
        JalrD = jr; BranchD = br; ALUSrcD = as; funct3D = f3;
        StallE = st; FlushE = fl;
    endtask

    task automatic drive_rand(input bit both_ok);
        int r;
        RegWriteD  = 1'($urandom);
        ResultSrcD = 2'($urandom_range(0, 2));
        MemWriteD  = 1'($urandom);
        JumpD      = ($urandom_range(0, 4) == 0);
        JalrD      = ($urandom_range(0, 4) == 0);
        BranchD    = 1'($urandom);
        ALUSrcD    = 1'($urandom);
        funct3D    = 3'($urandom);
        if (both_ok) begin
            StallE = 1'($urandom);
            FlushE = 1'($urandom);
        end else begin
            r = $urandom_range(0, 5);
            StallE = (r == 0);
            FlushE = (r == 1);
        end
    endtask

    // Flags derived from real operands so only consistent combinations appear.
    task automatic flags_rand();
        logic [31:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        ZeroE = (a == b);
        LtE   = ($signed(a) < $signed(b));
        LtuE  = (a < b);
    endtask

    initial begin
        logic [2:0] f3_list [7];
        f3_list = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
        rst = 1'b0;
        ZeroE = 1'b0; LtE = 1'b0; LtuE = 1'b0;
        drive_rand(1'b1);

        // Reset held with activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            check_all("reset_hold", 1'b1);
            drive_rand(1'b1);
        end
        rst = 1'b1;
        drive(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        clk_edge();
        check_all("reset_release", 1'b1);
        chk("reset_release.ValidE_const", 8'(ValidE), 8'd1);

        // Load word flows E then M.
        drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        clk_edge();
        check_all("lw_E", 1'b1);
        chk("lw_E.PCSrcE_const", 8'(PCSrcE), 8'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        clk_edge();
        check_all("lw_M", 1'b1);
        chk("lw_M.ResultSrcM_const", 8'(ResultSrcM), 8'd1);
        chk("lw_M.RegWriteM_const", 8'(RegWriteM), 8'd1);

        // Branch matrix: load once, then hold E while sweeping the ALU flags.
        foreach (f3_list[k]) begin
            drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f3_list[k], 1'b0, 1'b0);
            clk_edge();
            for (int fl = 0; fl < 8; fl++) begin
                StallE = 1'b1;
                clk_edge();
                {ZeroE, LtE, LtuE} = 3'(fl);
                #1;
                check_all($sformatf("br_f3=%0d_zlu=%0d", f3_list[k], fl), 1'b1);
            end
        end
        StallE = 1'b0;
        // Hand example: BGE with LtE=1 must not be taken.
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
        clk_edge();
        ZeroE = 1'b0; LtE = 1'b1; LtuE = 1'b0;
        #1;
        chk("bge_lt.PCSrcE_const", 8'(PCSrcE), 8'd0);

        // Jumps, including the illegal JAL+JALR decode and a flushed jump.
        drive(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        clk_edge();
        check_all("jal", 1'b1);
        chk("jal.PCSrcE_const", 8'(PCSrcE), 8'd1);
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        clk_edge();
        check_all("jalr", 1'b1);
        chk("jalr.PCSrcE_const", 8'(PCSrcE), 8'd2);
        drive(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        clk_edge();
        check_all("jal_jalr", 1'b1);
        chk("jal_jalr.PCSrcE_const", 8'(PCSrcE), 8'd2);
        drive(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        clk_edge();
        check_all("jump_flushed", 1'b1);
        chk("jump_flushed.PCSrcE_const", 8'(PCSrcE), 8'd0);
        chk("jump_flushed.ValidE_const", 8'(ValidE), 8'd0);

        // Store held by two stall cycles; M sees bubbles, then stall+flush clears E.
        drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        clk_edge();
        check_all("sw_E", 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
            clk_edge();
            check_all($sformatf("sw_stall%0d", i), 1'b1);
            chk($sformatf("sw_stall%0d.MemWriteE_const", i), 8'(MemWriteE), 8'd1);
            chk($sformatf("sw_stall%0d.ValidM_const", i), 8'(ValidM), 8'd0);
        end
        drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        clk_edge();
        check_all("stall_flush", 1'b0);
        chk("stall_flush.ValidE_const", 8'(ValidE), 8'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        clk_edge();
        check_all("after_flush", 1'b1);

        // Asynchronous reset between edges with both stages occupied.
        drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        clk_edge();
        clk_edge();
        check_all("pre_async", 1'b1);
        #2;
        rst = 1'b0;
        slot_e = '0;
        slot_m = '0;
        #1;
        check_all("async_reset", 1'b1);
        chk("async_reset.ValidM_const", 8'(ValidM), 8'd0);
        clk_edge();
        rst = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'b0);
            clk_edge();
            flags_rand();
            #1;
            check_all($sformatf("rand%0d", i), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
